// File: rtl/mem_pkg.sv
// Shared definitions for the memory loader/responder: FSM encoding and word geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] DEFAULT_MMIO_ADDR = 32'hFFFF_FFFC;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; a final byte zero-fills the rest.
module byte_word_assembler
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        last,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  byte_idx;
  logic [31:0] partial;

  // Bytes at and above byte_idx in partial are always zero, so OR-ing places the new byte.
  always_comb begin
    word_data  = partial | (32'(byte_in) << {byte_idx, 3'b000});
    word_valid = byte_valid & ((byte_idx == 2'(BYTES_PER_WORD - 1)) | last);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= 2'd0;
      partial  <= 32'd0;
    end else if (byte_valid) begin
      if (word_valid) begin
        byte_idx <= 2'd0;
        partial  <= 32'd0;
      end else begin
        byte_idx <= byte_idx + 2'd1;
        partial  <= word_data;
      end
    end
  end

endmodule

// File: rtl/mem_loader_responder.sv
// Unified memory for the multicycle core, boot-filled by a byte loader while the core is held in reset.
// Optional MEM_MMIO_EN adds a store/load output register at MMIO_ADDR.
module mem_loader_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LOAD_WORDS  = 64,
  parameter logic [31:0] MMIO_ADDR   = DEFAULT_MMIO_ADDR
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    Adr,
  input  logic [31:0]                    WriteData,
  input  logic                           MemWrite,
  output logic [31:0]                    ReadData,
  input  logic                           ld_valid,
  input  logic [7:0]                     ld_byte,
  input  logic                           ld_last,
  output logic                           ld_ready,
  output logic                           cpu_reset,
  output logic                           load_done,
  output logic [$clog2(DEPTH_WORDS):0]   words_loaded,
  output state_t                         fsm_state
`ifdef MEM_MMIO_EN
  ,
  output logic [31:0]                    mmio_out
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;

  state_t         state;
  logic [31:0]    mem [DEPTH_WORDS];
  logic [AW-1:0]  core_idx;
  logic           loader_full;
  logic           load_target;
  logic           accept;
  logic           word_valid;
  logic [31:0]    word_data;
  logic           mmio_hit;
  logic           unused_bits;

  // Loader handshake: a byte moves on a rising edge where ld_valid and ld_ready are both high;
  // ld_ready depends only on state and reset, never on ld_valid.
  assign ld_ready    = (state == LOAD) & ~reset;
  assign loader_full = (words_loaded == CW'(DEPTH_WORDS));
  assign load_target = (words_loaded == CW'(LOAD_WORDS));
  assign accept      = ld_valid & ld_ready & ~loader_full & ~load_target;
  assign core_idx    = Adr[AW+1:2];
  assign fsm_state   = state;

  byte_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (accept),
    .byte_in    (ld_byte),
    .last       (ld_last),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

`ifdef MEM_MMIO_EN
  assign mmio_hit = (Adr == MMIO_ADDR);
  assign ReadData = mmio_hit ? mmio_out : mem[core_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    mmio_out <= 32'd0;
    else if ((state == RUN) && MemWrite && mmio_hit) mmio_out <= WriteData;
  end
`else
  assign mmio_hit = 1'b0;
  assign ReadData = mem[core_idx];
`endif

  // Address bits outside the word index only matter for the MMIO decode.
  assign unused_bits = ^{Adr[31:AW+2], Adr[1:0], MMIO_ADDR};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LOAD;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (loader_full || load_target) begin
            state <= FLUSH;
          end else if (word_valid) begin
            words_loaded <= words_loaded + CW'(1);
            if (ld_last || (words_loaded + CW'(1) == CW'(LOAD_WORDS))) state <= FLUSH;
          end
        end
        FLUSH: begin
          load_done <= 1'b1;
          state     <= RUN;
        end
        RUN:     cpu_reset <= 1'b0;
        default: state <= LOAD;
      endcase
    end
  end

  // Array has no reset: contents survive a reset and are overwritten by the next load.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && word_valid)
      mem[words_loaded[AW-1:0]] <= word_data;
    else if ((state == RUN) && MemWrite && !mmio_hit)
      mem[core_idx] <= WriteData;
  end

endmodule

// File: tb/tb_mem_loader_responder.sv
// Self-checking bench for mem_loader_responder: boot load, reset mid-load, run-time reads/writes, optional MMIO.
module tb_mem_loader_responder;
  import mem_pkg::*;

  localparam int DEPTH = 16;
  localparam int LOADW = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic [31:0]   Adr;
  logic [31:0]   WriteData;
  logic          MemWrite;
  logic [31:0]   ReadData;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_last;
  logic          ld_ready;
  logic          cpu_reset;
  logic          load_done;
  logic [CW-1:0] words_loaded;
  state_t        fsm_state;
`ifdef MEM_MMIO_EN
  logic [31:0]   mmio_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_word;
  int          model_idx;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  mem_loader_responder #(
    .DEPTH_WORDS (DEPTH),
    .LOAD_WORDS  (LOADW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Adr          (Adr),
    .WriteData    (WriteData),
    .MemWrite     (MemWrite),
    .ReadData     (ReadData),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .words_loaded (words_loaded),
    .fsm_state    (fsm_state)
`ifdef MEM_MMIO_EN
    ,
    .mmio_out     (mmio_out)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_word = 32'd0;
    model_idx  = 0;
  endtask

  // Drives one loader byte; the reference packer pushes each completed word to exp_q.
  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk);
    check("ld_ready_before_byte", {31'd0, ld_ready}, 32'd1);
    if (ld_ready !== 1'b1) return;
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    model_word = model_word | (32'(b) << (8 * model_idx));
    if (model_idx == 3 || last) begin
      exp_q.push_back(model_word);
      model_reset();
    end else begin
      model_idx++;
    end
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [31:0] adr, input logic [31:0] exp);
    @(negedge clk);
    Adr = adr;
    #1;
    check(name, ReadData, exp);
  endtask

  task automatic check_read_pop(input string name, input logic [31:0] adr);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty queue expected a word", name);
      return;
    end
    e = exp_q.pop_front();
    check_read(name, adr, e);
  endtask

  initial begin
    reset = 1'b1; Adr = 32'd0; WriteData = 32'd0; MemWrite = 1'b0;
    ld_valid = 1'b0; ld_byte = 8'd0; ld_last = 1'b0;
    model_reset();

    vecs[0] = '{32'h08, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[1] = '{32'h0A, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D};
    vecs[2] = '{32'h08 + DEPTH * 4, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D};
    vecs[3] = '{32'h00, 1'b0, 32'h0, 1'b1, 32'h12345678};
    vecs[4] = '{32'h04, 1'b1, 32'hA5A5A5A5, 1'b1, 32'hDEADBEEF};
    vecs[5] = '{32'h07, 1'b0, 32'h0, 1'b1, 32'hA5A5A5A5};
    vecs[6] = '{32'h3C, 1'b1, 32'h0F0F0F0F, 1'b0, 32'h0};
    vecs[7] = '{32'h3C + DEPTH * 12, 1'b0, 32'h0, 1'b1, 32'h0F0F0F0F};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_state", 32'(fsm_state), 32'(LOAD));
`ifdef MEM_MMIO_EN
    check("rst_mmio_out", mmio_out, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Two-word boot image without ld_last
    send_byte(8'h78, 1'b0); send_byte(8'h56, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'h12, 1'b0);
    check("a_words_after_1", 32'(words_loaded), 32'd1);
    send_byte(8'hEF, 1'b0); send_byte(8'hBE, 1'b0); send_byte(8'hAD, 1'b0); send_byte(8'hDE, 1'b0);
    check("a_state_flush", 32'(fsm_state), 32'(FLUSH));
    check("a_words_after_2", 32'(words_loaded), 32'd2);
    check("a_load_done_not_yet", {31'd0, load_done}, 32'd0);
    check("a_ready_dropped", {31'd0, ld_ready}, 32'd0);
    step();
    check("a_state_run", 32'(fsm_state), 32'(RUN));
    check("a_load_done", {31'd0, load_done}, 32'd1);
    check("a_cpu_reset_held", {31'd0, cpu_reset}, 32'd1);
    step();
    check("a_cpu_reset_released", {31'd0, cpu_reset}, 32'd0);
    check_read_pop("a_mem0", 32'h00);
    check_read_pop("a_mem1", 32'h04);

    // Loader bytes offered in RUN are ignored
    @(negedge clk);
    ld_valid = 1'b1; ld_byte = 8'h99;
    repeat (3) step();
    check("run_ld_ready", {31'd0, ld_ready}, 32'd0);
    ld_valid = 1'b0;
    check("run_words_unchanged", 32'(words_loaded), 32'd2);
    check_read("run_mem0_unchanged", 32'h00, 32'h12345678);

    // Run-time read/write table; reads sampled before the edge see the old word
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      Adr = vecs[i].adr; MemWrite = vecs[i].we; WriteData = vecs[i].wdata;
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d_read", i), ReadData, vecs[i].exp);
      step();
      MemWrite = 1'b0;
    end

    // Reset in the middle of a load
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'h05, 1'b0);
    check("b_words_before_reset", 32'(words_loaded), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("b_async_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("b_async_words", 32'(words_loaded), 32'd0);
    check("b_async_ready", {31'd0, ld_ready}, 32'd0);
    check("b_async_load_done", {31'd0, load_done}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_read_pop("b_mem0_partial_load", 32'h00);
    check_read("b_mem1_kept", 32'h04, 32'hA5A5A5A5);

    // Short image ending on ld_last, with core stores attempted during LOAD and FLUSH
    @(negedge clk);
    Adr = 32'h08; MemWrite = 1'b1; WriteData = 32'hBAD0BAD0;
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b1);
    check("c_state_flush", 32'(fsm_state), 32'(FLUSH));
    check("c_words", 32'(words_loaded), 32'd1);
    step();
    MemWrite = 1'b0;
    check("c_state_run", 32'(fsm_state), 32'(RUN));
    check("c_load_done", {31'd0, load_done}, 32'd1);
    step();
    check("c_cpu_reset_released", {31'd0, cpu_reset}, 32'd0);
    check_read_pop("c_mem0_zero_fill", 32'h00);
    check_read("c_mem2_no_load_write", 32'h08, 32'hCAFEF00D);
    check_read("c_mem1_kept", 32'h04, 32'hA5A5A5A5);
    check("c_queue_empty", exp_q.size(), 32'd0);

    // Store to the output-register address
    @(negedge clk);
    Adr = DEFAULT_MMIO_ADDR; MemWrite = 1'b1;
`ifdef MEM_MMIO_EN
    WriteData = 32'h0000_0055;
    step();
    MemWrite = 1'b0;
    check("mmio_out", mmio_out, 32'h55);
    check_read("mmio_read", DEFAULT_MMIO_ADDR, 32'h55);
    check_read("mmio_array_untouched", 32'h3C, 32'h0F0F0F0F);
`else
    WriteData = 32'h0000_0077;
    step();
    MemWrite = 1'b0;
    check_read("mmio_addr_wraps", 32'h3C, 32'h77);
    check_read("mmio_addr_read_wrapped", DEFAULT_MMIO_ADDR, 32'h77);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
